// File: rtl/i2s_mc_tx_pkg.sv
// Shared types and elaboration helpers for the multi-line I2S transmitter.
// Default geometry plus functions that derive widths from the per-instance parameters.
package i2s_mc_tx_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam int DEF_NUM_PAIRS  = 4;
  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_SLOT_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int FRAME_W        = 2 * DEF_NUM_PAIRS * DEF_DATA_WIDTH;

  function automatic int frame_w(input int num_pairs, input int data_width);
    return 2 * num_pairs * data_width;
  endfunction

  function automatic int pos_w(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The one-bit I2S delay needs at least one spare slot bit after the LSB.
  function automatic bit cfg_ok(input int data_width, input int slot_width, input int depth);
    return (data_width < slot_width) && (depth >= 1) && (depth <= 65535) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/i2s_mc_tx_fifo.sv
// Synchronous frame FIFO with occupancy count; read data is shown ahead of the pop.
// Count moves one cycle after push/pop; pushes are dropped while full, pops while empty.
module i2s_mc_tx_fifo
  import i2s_mc_tx_pkg::*;
#(
  parameter int WIDTH = FRAME_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     aud_mclk,
  input  logic                     aud_mrst,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    do_wr = wr_vld && !full;
    do_rd = rd_rdy && !empty;
  end

  always_ff @(posedge aud_mclk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/i2s_mc_tx_core.sv
// Multi-line I2S transmitter: frame FIFO feeding NUM_PAIRS MSB-first serialisers, sclk/lrclk from aud_mclk.
// Frames pop only at frame start; s_tready drops while the FIFO is full; an empty FIFO at frame start sends zeros and raises irq.
module i2s_mc_tx_core
  import i2s_mc_tx_pkg::*;
#(
  parameter int NUM_PAIRS  = DEF_NUM_PAIRS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              aud_mclk,
  input  logic                              aud_mrst,
  input  logic                              ctrl_en,
  input  logic [7:0]                        cfg_sclk_div,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [2*NUM_PAIRS*DATA_WIDTH-1:0] s_tdata,
  output logic [15:0]                       fifo_wrdata_count,
  input  logic                              irq_clr,
  output logic                              irq,
  output logic                              sclk_out,
  output logic                              lrclk_out,
  output logic [NUM_PAIRS-1:0]              sdata_out
);

  localparam int FW = frame_w(NUM_PAIRS, DATA_WIDTH);
  localparam int PW = pos_w(SLOT_WIDTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [PW-1:0] POS_LAST = PW'(2 * SLOT_WIDTH - 1);
  localparam logic [PW-1:0] SLOT_P   = PW'(SLOT_WIDTH);
  localparam logic [PW-1:0] DW_P     = PW'(DATA_WIDTH);

  generate
    if (!cfg_ok(DATA_WIDTH, SLOT_WIDTH, FIFO_DEPTH)) begin : g_bad_cfg
      $error("i2s_mc_tx_core: need DATA_WIDTH < SLOT_WIDTH and power-of-2 FIFO_DEPTH <= 65535");
    end
  endgenerate

  state_t                state_q;
  logic [7:0]            div_q;
  logic [7:0]            div_cnt_q;
  logic                  sclk_q;
  logic                  lrclk_q;
  logic [NUM_PAIRS-1:0]  sdata_q;
  logic [PW-1:0]         pos_q;
  logic                  first_q;
  logic                  irq_q;
  logic [DATA_WIDTH-1:0] sh_l [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] sh_r [NUM_PAIRS];

  logic [FW-1:0]         fifo_rd_dat;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic [7:0]            div_eff;
  logic                  tick;
  logic                  fall;
  logic                  wrap;
  logic                  stopping;
  logic                  frame_start;
  logic [PW-1:0]         pos_nx;
  logic                  in_right;
  logic [PW-1:0]         slot_p;
  logic                  data_bit;

  always_comb begin
    div_eff     = (cfg_sclk_div == 8'd0) ? 8'd1 : cfg_sclk_div;
    tick        = (state_q != IDLE) && (div_cnt_q == div_q - 8'd1);
    fall        = tick && sclk_q;
    // Wrap point: either the very first fall after enabling or the end of bit 2*SLOT_WIDTH-1.
    wrap        = first_q || (pos_q == POS_LAST);
    stopping    = (state_q == STOP) && !ctrl_en;
    frame_start = fall && wrap && !stopping;
    pos_nx      = pos_q + PW'(1);
    in_right    = (pos_nx >= SLOT_P);
    slot_p      = in_right ? (pos_nx - SLOT_P) : pos_nx;
    data_bit    = (slot_p != '0) && (slot_p <= DW_P);
  end

  i2s_mc_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aud_mclk (aud_mclk),
    .aud_mrst (aud_mrst),
    .wr_vld   (s_tvalid),
    .wr_dat   (s_tdata),
    .rd_rdy   (frame_start),
    .rd_dat   (fifo_rd_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= '0;
      pos_q     <= '0;
      first_q   <= 1'b1;
      irq_q     <= 1'b0;
      for (int k = 0; k < NUM_PAIRS; k++) begin
        sh_l[k] <= '0;
        sh_r[k] <= '0;
      end
    end else begin
      if (irq_clr) irq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q    <= 1'b0;
          lrclk_q   <= 1'b0;
          sdata_q   <= '0;
          div_cnt_q <= '0;
          pos_q     <= '0;
          first_q   <= 1'b1;
          if (ctrl_en) begin
            state_q <= RUN;
            div_q   <= div_eff;
          end
        end
        default: begin
          if (state_q == RUN && !ctrl_en)      state_q <= STOP;
          else if (state_q == STOP && ctrl_en) state_q <= RUN;
          div_cnt_q <= tick ? 8'd0 : div_cnt_q + 8'd1;
          if (tick) sclk_q <= !sclk_q;
          if (fall) begin
            if (wrap && stopping) begin
              state_q <= IDLE;
              lrclk_q <= 1'b0;
              sdata_q <= '0;
              pos_q   <= '0;
              first_q <= 1'b1;
            end else if (wrap) begin
              pos_q   <= '0;
              first_q <= 1'b0;
              div_q   <= div_eff;
              lrclk_q <= 1'b0;
              sdata_q <= '0;
              if (fifo_empty) irq_q <= 1'b1;
              for (int k = 0; k < NUM_PAIRS; k++) begin
                sh_l[k] <= fifo_empty ? '0 : fifo_rd_dat[2*k*DATA_WIDTH +: DATA_WIDTH];
                sh_r[k] <= fifo_empty ? '0 : fifo_rd_dat[(2*k+1)*DATA_WIDTH +: DATA_WIDTH];
              end
            end else begin
              pos_q   <= pos_nx;
              lrclk_q <= in_right;
              for (int k = 0; k < NUM_PAIRS; k++) begin
                if (!data_bit) begin
                  sdata_q[k] <= 1'b0;
                end else if (in_right) begin
                  sdata_q[k] <= sh_r[k][DATA_WIDTH-1];
                  sh_r[k]    <= sh_r[k] << 1;
                end else begin
                  sdata_q[k] <= sh_l[k][DATA_WIDTH-1];
                  sh_l[k]    <= sh_l[k] << 1;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign s_tready          = !fifo_full;
  assign fifo_wrdata_count = 16'(fifo_count);
  assign irq               = irq_q;
  assign sclk_out          = sclk_q;
  assign lrclk_out         = lrclk_q;
  assign sdata_out         = sdata_q;

endmodule

// File: tb/tb_i2s_mc_tx_core.sv
// Bench for i2s_mc_tx_core: expected serial bits queued per frame, popped by a monitor on every sclk fall.
module tb_i2s_mc_tx_core;

  logic        aud_mclk;
  logic        aud_mrst;
  logic        ctrl_en;
  logic [7:0]  cfg_sclk_div;
  logic        s_tvalid;
  logic        s_tready;
  logic [95:0] s_tdata;
  logic [15:0] fifo_wrdata_count;
  logic        irq_clr;
  logic        irq;
  logic        sclk_out;
  logic        lrclk_out;
  logic [1:0]  sdata_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q [$];
  int mon_idx = 0;
  logic sclk_prev = 1'b0;

  i2s_mc_tx_core #(
    .NUM_PAIRS  (2),
    .DATA_WIDTH (24),
    .SLOT_WIDTH (32),
    .FIFO_DEPTH (8)
  ) dut (
    .aud_mclk          (aud_mclk),
    .aud_mrst          (aud_mrst),
    .ctrl_en           (ctrl_en),
    .cfg_sclk_div      (cfg_sclk_div),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .s_tdata           (s_tdata),
    .fifo_wrdata_count (fifo_wrdata_count),
    .irq_clr           (irq_clr),
    .irq               (irq),
    .sclk_out          (sclk_out),
    .lrclk_out         (lrclk_out),
    .sdata_out         (sdata_out)
  );

  initial aud_mclk = 1'b0;
  always #5 aud_mclk = ~aud_mclk;

  // Monitor: each sclk fall presents {lrclk, sdata[1:0]} for the next bit position.
  always @(negedge aud_mclk) begin
    logic [2:0] e;
    if (sclk_prev && !sclk_out && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({lrclk_out, sdata_out} !== e) begin
        n_fail++;
        $display("FAIL serial_bit[%0d]: got lr/sdata %b, expected %b", mon_idx, {lrclk_out, sdata_out}, e);
      end
      mon_idx++;
    end
    sclk_prev = sclk_out;
  end

  task automatic step(input int n);
    repeat (n) @(posedge aud_mclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] mk_frame(input logic [23:0] l0, input logic [23:0] r0,
                                           input logic [23:0] l1, input logic [23:0] r1);
    return {r1, l1, r0, l0};
  endfunction

  task automatic push_exp(input logic [95:0] f);
    int p;
    logic lr;
    logic [1:0] sd;
    logic [23:0] w;
    for (int pos = 0; pos < 64; pos++) begin
      p  = pos % 32;
      lr = (pos >= 32);
      for (int k = 0; k < 2; k++) begin
        w = f[(2*k + int'(lr))*24 +: 24];
        sd[k] = (p >= 1 && p <= 24) ? w[24-p] : 1'b0;
      end
      exp_q.push_back({lr, sd});
    end
  endtask

  task automatic send_frame(input logic [95:0] f);
    int t = 0;
    s_tdata  = f;
    s_tvalid = 1'b1;
    while (!s_tready && t < 200) begin step(1); t++; end
    check("send_ready", s_tready, 1);
    step(1);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int t = 0;
    while (fifo_wrdata_count != 16'(target) && t < budget) begin step(1); t++; end
    check(name, fifo_wrdata_count, target);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int t = 0;
    while (exp_q.size() > 0 && t < budget) begin step(1); t++; end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_lr(input logic val, input int budget, input string name);
    int t = 0;
    while (lrclk_out !== val && t < budget) begin step(1); t++; end
    check(name, lrclk_out, val);
  endtask

  task automatic count_falls(input int n);
    int c = 0;
    int t = 0;
    logic prev = sclk_out;
    while (c < n && t < 2000) begin
      step(1); t++;
      if (prev && !sclk_out) c++;
      prev = sclk_out;
    end
    check("fall_count", c, n);
  endtask

  task automatic measure_period(output int cyc);
    int t = 0;
    logic prev = sclk_out;
    cyc = 0;
    while (!(!prev && sclk_out) && t < 100) begin prev = sclk_out; step(1); t++; end
    prev = sclk_out;
    step(1); cyc = 1;
    while (!(!prev && sclk_out) && cyc < 100) begin prev = sclk_out; step(1); cyc++; end
  endtask

  task automatic irq_pulse();
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
  endtask

  initial begin
    logic [95:0] f1, f2, f3, g [9];
    int per;
    int bad;

    aud_mrst = 1'b1; ctrl_en = 1'b0; cfg_sclk_div = 8'd2;
    s_tvalid = 1'b0; s_tdata = '0; irq_clr = 1'b0;
    step(3);
    aud_mrst = 1'b0;
    step(1);
    check("rst_sclk", sclk_out, 0);
    check("rst_lrclk", lrclk_out, 0);
    check("rst_sdata", sdata_out, 0);
    check("rst_irq", irq, 0);
    check("rst_count", fifo_wrdata_count, 0);
    check("rst_tready", s_tready, 1);

    // Single frame, then graceful stop partway through it.
    f1 = mk_frame(24'hA5A5A5, 24'h5A5A5A, 24'h800001, 24'h000001);
    send_frame(f1);
    check("single_count1", fifo_wrdata_count, 1);
    push_exp(f1);
    ctrl_en = 1'b1;
    wait_count(0, 20, "single_pop");
    count_falls(5);
    ctrl_en = 1'b0;
    wait_drain(400, "single_drain");
    step(20);
    check("single_idle_sclk", sclk_out, 0);
    check("single_idle_lr", lrclk_out, 0);
    check("single_idle_sd", sdata_out, 0);
    check("single_no_irq", irq, 0);

    // Stop at pos 10 with a second frame still queued.
    f2 = mk_frame(24'h123456, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0);
    f3 = mk_frame(24'hC00003, 24'h3FFFFC, 24'h555555, 24'hAAAAAA);
    send_frame(f2);
    send_frame(f3);
    check("stop_count2", fifo_wrdata_count, 2);
    push_exp(f2);
    ctrl_en = 1'b1;
    wait_count(1, 20, "stop_pop");
    count_falls(10);
    ctrl_en = 1'b0;
    wait_drain(400, "stop_drain");
    step(10);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (sclk_out || lrclk_out || sdata_out != 2'b00) bad++;
      step(1);
    end
    check("stop_idle_quiet", bad, 0);
    check("stop_count_kept", fifo_wrdata_count, 1);
    check("stop_no_irq", irq, 0);

    // Retained frame, then underflow frames and irq set/clear races.
    push_exp(f3);
    push_exp('0);
    ctrl_en = 1'b1;
    wait_count(0, 20, "uf_pop_retained");
    check("uf_irq_before", irq, 0);
    wait_drain(700, "uf_drain");
    step(8);
    check("uf_irq_set", irq, 1);
    irq_pulse();
    check("uf_irq_clr", irq, 0);
    wait_lr(1'b1, 400, "uf_wait_right");
    wait_lr(1'b0, 400, "uf_wait_start");
    check("uf_irq_set2", irq, 1);
    irq_pulse();
    check("uf_irq_clr2", irq, 0);
    wait_lr(1'b1, 400, "uf_wait_right2");
    step(127);
    check("uf_irq_pre_race", irq, 0);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("uf_race_frame_start", lrclk_out, 0);
    check("uf_set_wins", irq, 1);
    ctrl_en = 1'b0;
    step(300);
    check("uf_idle_sclk", sclk_out, 0);
    irq_pulse();
    check("uf_irq_final_clr", irq, 0);

    // Backpressure: nine frames into an eight-deep FIFO while idle.
    for (int i = 0; i < 9; i++)
      g[i] = mk_frame(24'(i * 24'h111111), 24'(~(i * 24'h111111)), 24'h800000 >> i, 24'(i + 1));
    for (int i = 0; i < 8; i++) send_frame(g[i]);
    check("bp_count8", fifo_wrdata_count, 8);
    check("bp_tready0", s_tready, 0);
    s_tdata  = g[8];
    s_tvalid = 1'b1;
    step(5);
    check("bp_stall_count", fifo_wrdata_count, 8);
    for (int i = 0; i < 9; i++) push_exp(g[i]);
    ctrl_en = 1'b1;
    bad = 0;
    while (!s_tready && bad < 50) begin step(1); bad++; end
    check("bp_ready_after_pop", s_tready, 1);
    step(1);
    s_tvalid = 1'b0;
    check("bp_count_refill", fifo_wrdata_count, 8);
    check("bp_tready_refill", s_tready, 0);
    wait_count(0, 2500, "bp_last_pop");
    ctrl_en = 1'b0;
    wait_drain(400, "bp_drain");
    check("bp_no_irq", irq, 0);
    step(20);

    // Divider: 0 acts as 1, and changes only take effect at a frame start.
    cfg_sclk_div = 8'd0;
    ctrl_en = 1'b1;
    step(10);
    measure_period(per);
    check("div0_period", per, 2);
    ctrl_en = 1'b0;
    step(300);
    cfg_sclk_div = 8'd2;
    ctrl_en = 1'b1;
    step(20);
    measure_period(per);
    check("div2_period", per, 4);
    cfg_sclk_div = 8'd5;
    measure_period(per);
    check("div_hold_period", per, 4);
    wait_lr(1'b1, 600, "div_wait_right");
    wait_lr(1'b0, 600, "div_wait_start");
    measure_period(per);
    check("div5_period", per, 10);

    // Reset while running with frames queued.
    send_frame(f1);
    send_frame(f2);
    check("rrst_count_pre", fifo_wrdata_count, 2);
    aud_mrst = 1'b1;
    ctrl_en  = 1'b0;
    step(1);
    aud_mrst = 1'b0;
    check("rrst_sclk", sclk_out, 0);
    check("rrst_lrclk", lrclk_out, 0);
    check("rrst_sdata", sdata_out, 0);
    check("rrst_irq", irq, 0);
    check("rrst_count", fifo_wrdata_count, 0);
    check("rrst_tready", s_tready, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (sclk_out) bad++;
    end
    check("rrst_sclk_quiet", bad, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_mc_tx_core.md
Name: i2s_mc_tx_core

Overview:
- Multi-line I2S transmitter core. Clocked by the audio master clock.
- Accepts whole stereo frames for NUM_PAIRS data lines over a valid/ready stream and buffers them in a frame FIFO.
- Generates sclk_out and lrclk_out from aud_mclk with a programmable divider, and serialises frames MSB-first in I2S format, one sdata line per stereo pair.
- Sits between the AXI-Stream sample path and the I2S pins. Generalises the single-line transmitter with configurable width, slot size, line count and FIFO depth, adds graceful stop, and adds underflow reporting through a sticky irq.

Parameters:
- NUM_PAIRS, 4: number of stereo data lines (sdata_out bits).
- DATA_WIDTH, 24: sample width. Must satisfy DATA_WIDTH < SLOT_WIDTH.
- SLOT_WIDTH, 32: sclk cycles per channel slot (half frame).
- FIFO_DEPTH, 8: frame FIFO entries. Power of 2, at most 65535.

Ports:
- aud_mclk  in  1  audio master clock; the only clock.
- aud_mrst  in  1  reset, synchronous, active-high.
- ctrl_en  in  1  transmitter enable, level.
- cfg_sclk_div  in  8  sclk half-period in aud_mclk cycles; 0 is treated as 1.
- s_tvalid  in  1  frame valid.
- s_tready  out  1  frame ready.
- s_tdata  in  2*NUM_PAIRS*DATA_WIDTH  frame data. Pair k left = bits [(2k+1)*DATA_WIDTH-1 : 2k*DATA_WIDTH]; right = the next DATA_WIDTH bits up.
- fifo_wrdata_count  out  16  FIFO occupancy, zero-extended.
- irq_clr  in  1  single-cycle clear of irq.
- irq  out  1  sticky underflow interrupt.
- sclk_out  out  1  serial bit clock.
- lrclk_out  out  1  word select: 0 = left, 1 = right.
- sdata_out  out  NUM_PAIRS  serial data, one line per pair.

Behaviour:
- Reset (aud_mrst=1 at a rising edge of aud_mclk):
  - sclk_out, lrclk_out, sdata_out, irq = 0.
  - FIFO flushed; fifo_wrdata_count = 0; s_tready = 1.
  - State = IDLE. Divider and bit counters = 0.
  - Reset mid-frame aborts the frame immediately; no partial output follows.
- FIFO:
  - s_tready = (count != FIFO_DEPTH). Push on s_tvalid & s_tready.
  - Pop only at frame start. Push and pop in the same cycle leave the count unchanged.
  - Count updates the cycle after the event.
- Divider:
  - div = max(cfg_sclk_div, 1), sampled at every frame start; constant within a frame.
  - div_cnt counts 0..div-1 in RUN/STOP; sclk_out toggles when div_cnt == div-1.
  - sclk period = 2*div mclk cycles.
  - "Fall tick" = a toggle while sclk_out == 1.
  - All lrclk_out and sdata_out updates are registered on fall ticks only.
- Bit position pos runs 0..2*SLOT_WIDTH-1 and wraps:
  - lrclk_out = (pos >= SLOT_WIDTH).
  - Slot position p = pos mod SLOT_WIDTH.
  - sdata_out[k] = word[DATA_WIDTH-p] for 1 <= p <= DATA_WIDTH, else 0. This is the I2S one-bit delay, MSB at p = 1.
- State machine:
  - IDLE: sclk, lrclk and sdata held 0; counters cleared. ctrl_en=1 -> RUN (next cycle, div_cnt=0, sclk starts low).
  - RUN: the first fall tick after entry is frame start, pos=0.
  - At every frame start (pos wraps to 0):
    - If the FIFO is non-empty: pop and load all shift registers.
    - If the FIFO is empty: load zeros, count underflow, set irq.
  - RUN: ctrl_en=0 -> STOP.
  - STOP: completes the current frame; at the fall tick where pos would wrap, go to IDLE (no pop). ctrl_en re-asserted in STOP -> RUN, frame continues seamlessly.
- irq: set on an underflow frame start; cleared by irq_clr. Set wins when both occur in the same cycle. Underflow is not flagged while in IDLE.
- Data written while IDLE is retained and used when the core is next enabled.

Decomposition:
- Package i2s_mc_tx_pkg:
  - state enum typedef (IDLE, RUN, STOP).
  - Derived localparams: FRAME_W = 2*NUM_PAIRS*DATA_WIDTH, POS_W = $clog2(2*SLOT_WIDTH), CNT_W = $clog2(FIFO_DEPTH+1).
  - Elaboration check that DATA_WIDTH < SLOT_WIDTH.
- Sub-module i2s_mc_tx_fifo: synchronous FIFO, FRAME_W wide, FIFO_DEPTH deep, with count, full and empty outputs.

Test Plan (NUM_PAIRS=2, DATA_WIDTH=24, SLOT_WIDTH=32, FIFO_DEPTH=8, cfg_sclk_div=2):
- Reset mid-RUN: assert aud_mrst for 1 cycle -> next cycle all outputs 0, count 0, s_tready=1; 10 cycles of ctrl_en=0 keep sclk_out=0.
- Single frame:
  - Stimulus: push pair0 L=0xA5A5A5 R=0x5A5A5A, pair1 L=0x800001 R=0x000001, then ctrl_en=1.
  - Clocking: sclk period = 4 mclk; lrclk low for 32 sclk, then high for 32.
  - sdata_out[0]: p=0 bit is 0; p=1..24 carries 1010...; p=25..31 are 0.
  - sdata_out[1]: 1 at p=1 and p=24 of the left slot, and at p=24 of the right slot.
  - Count goes 1 -> 0 at frame start.
- Backpressure: push 9 frames with the core IDLE -> s_tready=0 after the 8th; fifo_wrdata_count=8; 9th frame accepted only after the first pop.
- Underflow: enable with the FIFO empty -> sdata=0 for the whole frame; irq=1 after the first frame start; irq_clr pulse -> irq=0; a 2nd empty frame sets irq again; irq_clr coincident with a set -> irq stays 1.
- Graceful stop: drop ctrl_en at pos=10 -> frame completes to pos=63, then IDLE with outputs 0; remaining FIFO entries untouched.
- Divider change: cfg_sclk_div 0 -> sclk period 2 mclk; change 2 -> 5 mid-frame -> period stays 4 until the next frame start, then becomes 10.
